// File: rtl/oled_spi_tx.sv
// Byte-level 4-wire SPI transmitter (mode 0, MSB first) for the SSD1309 path.
// Buffers {dc, byte} words in a small FIFO and streams queued bytes under one cs-low window.
module oled_spi_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_dc,
    output logic       sclk,
    output logic       sdin,
    output logic       cmd,
    output logic       cs,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = $clog2(CLK_DIV) + 1;
    localparam int unsigned HW = $clog2(CS_HOLD) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ready_en;
    logic          push;
    logic          pop;
    logic [8:0]    head;

    logic [1:0]    state;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          phase_end;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // ready_en keeps in_ready low through reset and up to the first edge after release
    assign in_ready   = ready_en & ~fifo_full;
    assign push       = in_valid & in_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign busy       = (state != IDLE) | ~fifo_empty;
    assign phase_end  = (div_cnt == DW'(CLK_DIV - 1));

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE, HOLD: pop = ~fifo_empty;
            SHIFT:      pop = sclk & phase_end & (bit_idx == 3'd0) & ~fifo_empty;
            default:    pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_dc, in_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sclk     <= 1'b0;
            sdin     <= 1'b0;
            cmd      <= 1'b0;
            cs       <= 1'b1;
            bit_idx  <= '0;
            div_cnt  <= '0;
            hold_cnt <= '0;
            shreg    <= '0;
        end else if (pop) begin
            // Byte start from IDLE, HOLD or the end of the previous byte; cs stays low.
            state   <= SHIFT;
            cs      <= 1'b0;
            cmd     <= head[8];
            sdin    <= head[7];
            shreg   <= head[7:0];
            bit_idx <= 3'd7;
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_idx != 3'd0) begin
                                bit_idx <= bit_idx - 3'd1;
                                sdin    <= shreg[bit_idx - 3'd1];
                            end else begin
                                state    <= HOLD;
                                hold_cnt <= '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HW'(CS_HOLD - 1)) begin
                        cs    <= 1'b1;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx: one instance at CLK_DIV=2, one at CLK_DIV=1,
// SPI lines observed on the falling clk edge.
module tb_oled_spi_tx;

    typedef logic bitq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_dc, in_ready, sclk, sdin, cmd, cs, busy;
    logic [7:0] in_data;
    logic       v1, dc1, rdy1, sclk1, sdin1, cmd1, cs1, busy1;
    logic [7:0] d1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    oled_spi_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .CS_HOLD(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dc(in_dc), .sclk(sclk), .sdin(sdin),
        .cmd(cmd), .cs(cs), .busy(busy)
    );

    oled_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .CS_HOLD(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1),
        .in_data(d1), .in_dc(dc1), .sclk(sclk1), .sdin(sdin1),
        .cmd(cmd1), .cs(cs1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bitq_t r_sd, r_cm, r_cs;
    int    cs_fall_cyc, cs_rise_cyc, last_fall_cyc, n_cs_fall, n_cs_rise;
    logic  p_sclk = 1'b0, p_cs = 1'b1;

    always @(negedge clk) begin
        if (sclk === 1'b1 && p_sclk === 1'b0) begin
            r_sd.push_back(sdin); r_cm.push_back(cmd); r_cs.push_back(cs);
        end
        if (sclk === 1'b0 && p_sclk === 1'b1) last_fall_cyc = cyc;
        if (cs === 1'b0 && p_cs === 1'b1) begin cs_fall_cyc = cyc; n_cs_fall++; end
        if (cs === 1'b1 && p_cs === 1'b0) begin cs_rise_cyc = cyc; n_cs_rise++; end
        p_sclk = sclk; p_cs = cs;
    end

    bitq_t r1_sd, r1_cm;
    int    r1_cyc[$];
    int    cs_fall1, last_fall1;
    logic  p_sclk1 = 1'b0, p_cs1 = 1'b1;

    always @(negedge clk) begin
        if (sclk1 === 1'b1 && p_sclk1 === 1'b0) begin
            r1_sd.push_back(sdin1); r1_cm.push_back(cmd1); r1_cyc.push_back(cyc);
        end
        if (sclk1 === 1'b0 && p_sclk1 === 1'b1) last_fall1 = cyc;
        if (cs1 === 1'b0 && p_cs1 === 1'b1) cs_fall1 = cyc;
        p_sclk1 = sclk1; p_cs1 = cs1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input bitq_t q, input int start, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            v = {v[62:0], (start + i < q.size()) ? q[start + i] : 1'bx};
        return v;
    endfunction

    task automatic clear_mon();
        r_sd.delete(); r_cm.delete(); r_cs.delete();
        n_cs_fall = 0; n_cs_rise = 0;
        cs_fall_cyc = 0; cs_rise_cyc = 0; last_fall_cyc = 0;
    endtask

    task automatic push(input logic dc, input logic [7:0] d, output int acc);
        int n = 0;
        in_valid = 1'b1; in_dc = dc; in_data = d;
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        check("push_timeout", (n < 500), 1);
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || !cs) && n < 2000);
        check(tag, (n < 2000), 1);
        #1;
    endtask

    int acc, acc6[6], n;
    logic [7:0] t4_bytes[6];

    initial begin
        in_valid = 1'b0; in_dc = 1'b0; in_data = '0;
        v1 = 1'b0; dc1 = 1'b0; d1 = '0;
        t4_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset state and in_ready release timing
        repeat (5) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_cs1", cs1, 1);
        reset = 1'b1;
        #1 check("ready_before_edge", in_ready, 0);
        @(negedge clk);
        check("ready_after_edge", in_ready, 1);
        check("busy_after_rel", busy, 0);
        #1 clear_mon();

        // Single command byte 0xAE
        push(1'b0, 8'hAE, acc);
        wait_idle("t2_idle");
        check("t2_nrise", r_sd.size(), 8);
        check("t2_bits", pack(r_sd, 0, 8), 64'hAE);
        check("t2_cmd", pack(r_cm, 0, 8), 64'h00);
        check("t2_cs_fall_lat", cs_fall_cyc - acc, 1);
        check("t2_last_fall", last_fall_cyc - cs_fall_cyc, 32);
        check("t2_cs_hold", cs_rise_cyc - last_fall_cyc, 2);
        check("t2_ncsfall", n_cs_fall, 1);
        clear_mon();

        // Four back-to-back bytes under one cs window
        push(1'b0, 8'h21, acc);
        push(1'b0, 8'h00, acc);
        push(1'b0, 8'h7F, acc);
        push(1'b1, 8'hFF, acc);
        wait_idle("t3_idle");
        check("t3_nrise", r_sd.size(), 32);
        check("t3_bits", pack(r_sd, 0, 32), 64'h21007FFF);
        check("t3_cmd", pack(r_cm, 0, 32), 64'h000000FF);
        check("t3_cs_at_rise", pack(r_cs, 0, 32), 64'h0);
        check("t3_ncsfall", n_cs_fall, 1);
        check("t3_ncsrise", n_cs_rise, 1);
        check("t3_span", last_fall_cyc - cs_fall_cyc, 128);
        clear_mon();

        // FIFO full back-pressure with six queued bytes
        for (int i = 0; i < 5; i++) push(1'b0, t4_bytes[i], acc6[i]);
        check("t4_ready_full", in_ready, 0);
        push(1'b0, t4_bytes[5], acc6[5]);
        for (int i = 1; i < 5; i++) check("t4_acc_seq", acc6[i] - acc6[0], i);
        check("t4_acc6", acc6[5] - acc6[0], 34);
        wait_idle("t4_idle");
        check("t4_nrise", r_sd.size(), 48);
        for (int i = 0; i < 6; i++) check("t4_byte", pack(r_sd, 8 * i, 8), {56'h0, t4_bytes[i]});
        check("t4_ncsfall", n_cs_fall, 1);
        clear_mon();

        // Async reset in mid-byte, then a clean byte
        in_valid = 1'b1; in_dc = 1'b0; in_data = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (r_sd.size() < 3 && n < 500) begin @(posedge clk); #1; n++; end
        check("t5_rise_timeout", (n < 500), 1);
        check("t5_sclk_high", sclk, 1);
        check("t5_first3", pack(r_sd, 0, 3), 64'h5);
        reset = 1'b0;
        #1;
        check("t5_cs_async", cs, 1);
        check("t5_sclk_async", sclk, 0);
        check("t5_busy_async", busy, 0);
        check("t5_ready_async", in_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 clear_mon();
        push(1'b0, 8'h3C, acc);
        wait_idle("t5_idle");
        check("t5_nrise", r_sd.size(), 8);
        check("t5_bits", pack(r_sd, 0, 8), 64'h3C);
        check("t5_ncsfall", n_cs_fall, 1);

        // CLK_DIV=1 instance, data byte 0x80
        @(negedge clk);
        v1 = 1'b1; dc1 = 1'b1; d1 = 8'h80;
        check("t6_ready", rdy1, 1);
        @(negedge clk);
        acc = cyc;
        v1 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while ((busy1 || !cs1) && n < 500);
        check("t6_idle", (n < 500), 1);
        #1;
        check("t6_nrise", r1_sd.size(), 8);
        check("t6_bits", pack(r1_sd, 0, 8), 64'h80);
        check("t6_cmd", pack(r1_cm, 0, 8), 64'hFF);
        check("t6_period", r1_cyc[1] - r1_cyc[0], 2);
        check("t6_rise_span", r1_cyc[7] - r1_cyc[0], 14);
        check("t6_cs_fall_lat", cs_fall1 - acc, 1);
        check("t6_byte_len", last_fall1 - cs_fall1, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
